csr_file_trap: RTL and testbench
================================

Name: csr_file_trap

Overview:
- Parametrised machine-mode CSR file for the npc core; successor to the fixed 32-bit CSR store.
- Adds atomic CSR ops (RW/RS/RC), illegal-access detection, hardware trap entry and mret state updates on mstatus/mepc/mcause, mscratch, and 64-bit mcycle/minstret counters.
- Sits beside the EXU/WBU. Exports mtvec/mepc to the IFU for redirect.

Parameters:
- XLEN, 32, register width; legal values are 32 or 64.
- MVENDORID_VAL, 32'h78797379, read-only mvendorid value (zero-extended to XLEN).
- MARCHID_VAL, 32'h017dc6a3, read-only marchid value (zero-extended to XLEN).

Ports:
- clock  in  1  clock
- reset  in  1  synchronous, active-high reset
- csr_valid_i  in  1  CSR instruction retires this cycle
- csr_op_i  in  2  01=RW, 10=RS (set), 11=RC (clear), 00=read-only/no write
- csr_addr_i  in  12  CSR address (read and write)
- csr_wsrc_i  in  XLEN  rs1 value or zimm
- csr_rdata_o  out  XLEN  old value of addressed CSR; combinational
- csr_illegal_o  out  1  illegal access; combinational, qualified by csr_valid_i
- trap_i  in  1  take exception this cycle
- trap_cause_i  in  XLEN  mcause value for the trap
- trap_pc_i  in  XLEN  PC of the faulting instruction
- mret_i  in  1  mret retires this cycle
- instret_i  in  1  an instruction retires this cycle
- mtvec_o  out  XLEN  current mtvec
- mepc_o  out  XLEN  current mepc
- mie_o  out  1  mstatus.MIE

Behaviour:
- Address map:
  - mstatus 0x300, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342
  - mcycle 0xB00, minstret 0xB02, mcycleh 0xB80, minstreth 0xB82 (h registers only when XLEN=32)
  - mvendorid 0xF11, marchid 0xF12
- Reset values: all writable CSRs and counters 0; mie_o=0; mtvec_o=0; mepc_o=0.
- Read value: csr_rdata_o is the pre-update value with no latency. An unmapped address reads 0.
- mstatus implements:
  - MIE (bit 3) and MPIE (bit 7): writable.
  - MPP (bits 12:11): reads constant 2'b11.
  - All other bits: read 0, writes ignored.
- mepc: bits [1:0] are forced to 0 on every write path.
- Effective write value:
  - RW: wsrc.
  - RS: old | wsrc.
  - RC: old & ~wsrc.
- Write enable = csr_valid_i && op!=00 && !(op in {RS,RC} && wsrc==0) && !illegal.
- csr_illegal_o=1 when csr_valid_i and either:
  - the address is unmapped (including h registers when XLEN=64), or
  - addr[11:10]==2'b11 (read-only space) and the write would otherwise occur.
  - An illegal access writes nothing.
- Trap (trap_i=1), all updated at the next edge:
  - mepc <= trap_pc_i & ~3
  - mcause <= trap_cause_i
  - MPIE <= MIE
  - MIE <= 0
- mret (mret_i=1): MIE <= MPIE; MPIE <= 1.
- Same-cycle priority:
  - trap_i > mret_i > CSR write for mstatus, mepc and mcause.
  - A trap suppresses a same-cycle CSR write to any register.
  - mret only suppresses writes to mstatus.
- Counters:
  - mcycle is 64-bit and increments every non-reset cycle.
  - minstret is 64-bit and increments when instret_i=1.
  - Both wrap from all-ones to 0.
  - A CSR write to a counter half (low or high word when XLEN=32; the full register when XLEN=64) replaces that half and suppresses that counter's increment in that cycle. The other half holds.
  - Carry from the low word into the high word applies only on an unsuppressed increment.
- mtvec_o, mepc_o and mie_o are register outputs. Updates are visible the cycle after the write or trap.
- Reset mid-operation: reset overrides trap, mret, write and increment; all state returns to reset values.

Test Plan:
- Reset then read 0xF11 and 0xF12 -> rdata 0x78797379 and 0x017dc6a3; a read of 0x305 -> 0; illegal=0.
- RW 0x305 with 0x80000100, then RS 0x305 with 0x3, then RC 0x305 with 0x100 -> reads 0x80000100, 0x80000103, 0x80000003; mtvec_o tracks one cycle later.
- RW 0x300 with 0x8, then trap_i with cause 0xB, pc 0x80000012 -> mepc=0x80000010, mcause=0xB, mstatus reads 0x1880. Next mret -> mstatus reads 0x1888.
- Same cycle trap_i and RW 0x341 with 0x1234 -> mepc = trap pc; 0x1234 discarded. RW 0xF11 with 0x1 -> illegal=1, value unchanged. RS 0xF11 with 0 -> illegal=0.
- Load mcycle=0xFFFFFFFF and mcycleh=0 (XLEN=32), then run 2 cycles -> mcycleh=1, mcycle=0x1. A write to 0xB00 on a cycle holds that value (no increment). minstret increments only on instret_i pulses.
- Assert reset mid-count, simultaneous with a trap -> all CSRs 0, mie_o=0, no trap side-effects; mcycle restarts from 0.

Source files
------------

// File: rtl/csr_file_trap_if.sv
// Bus between the pipeline (EXU/WBU/IFU side) and the machine-mode CSR file.
interface csr_file_trap_if #(
  parameter int XLEN = 32
);
  logic            csr_valid_i;
  logic [1:0]      csr_op_i;
  logic [11:0]     csr_addr_i;
  logic [XLEN-1:0] csr_wsrc_i;
  logic [XLEN-1:0] csr_rdata_o;
  logic            csr_illegal_o;
  logic            trap_i;
  logic [XLEN-1:0] trap_cause_i;
  logic [XLEN-1:0] trap_pc_i;
  logic            mret_i;
  logic            instret_i;
  logic [XLEN-1:0] mtvec_o;
  logic [XLEN-1:0] mepc_o;
  logic            mie_o;

  // Pipeline side: issues CSR ops, traps and retire pulses.
  modport master (
    output csr_valid_i, csr_op_i, csr_addr_i, csr_wsrc_i,
    output trap_i, trap_cause_i, trap_pc_i, mret_i, instret_i,
    input  csr_rdata_o, csr_illegal_o, mtvec_o, mepc_o, mie_o
  );

  // CSR file side.
  modport slave (
    input  csr_valid_i, csr_op_i, csr_addr_i, csr_wsrc_i,
    input  trap_i, trap_cause_i, trap_pc_i, mret_i, instret_i,
    output csr_rdata_o, csr_illegal_o, mtvec_o, mepc_o, mie_o
  );
endinterface

// File: rtl/csr_file_trap.sv
// Machine-mode CSR file: atomic RW/RS/RC ops, illegal-access detection,
// trap entry / mret on mstatus-mepc-mcause, mscratch and 64-bit counters.
module csr_file_trap #(
  parameter int          XLEN          = 32,
  parameter logic [31:0] MVENDORID_VAL = 32'h78797379,
  parameter logic [31:0] MARCHID_VAL   = 32'h017dc6a3
) (
  input logic            clock,
  input logic            reset,
  csr_file_trap_if.slave bus
);

  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_RW   = 2'b01,
    OP_RS   = 2'b10,
    OP_RC   = 2'b11
  } csr_op_e;

  localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
  localparam logic [11:0] ADDR_MTVEC     = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
  localparam logic [11:0] ADDR_MEPC      = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
  localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
  localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
  localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
  localparam logic [11:0] ADDR_MVENDORID = 12'hF11;
  localparam logic [11:0] ADDR_MARCHID   = 12'hF12;

  logic            mstatus_mie;
  logic            mstatus_mpie;
  logic [XLEN-1:0] mtvec_q;
  logic [XLEN-1:0] mscratch_q;
  logic [XLEN-1:0] mepc_q;
  logic [XLEN-1:0] mcause_q;
  logic [63:0]     mcycle_q;
  logic [63:0]     minstret_q;

  csr_op_e         op;
  logic [11:0]     addr;
  logic [XLEN-1:0] old_val;
  logic [XLEN-1:0] wr_val;
  logic            mapped;
  logic            write_req;
  logic            illegal;
  logic            we;

  assign op   = csr_op_e'(bus.csr_op_i);
  assign addr = bus.csr_addr_i;

  // Read mux: pre-update value of the addressed CSR; also flags unmapped addresses.
  always_comb begin
    old_val = '0;
    mapped  = 1'b1;
    case (addr)
      ADDR_MSTATUS: begin
        old_val[3]     = mstatus_mie;
        old_val[7]     = mstatus_mpie;
        old_val[12:11] = 2'b11;
      end
      ADDR_MTVEC:     old_val = mtvec_q;
      ADDR_MSCRATCH:  old_val = mscratch_q;
      ADDR_MEPC:      old_val = mepc_q;
      ADDR_MCAUSE:    old_val = mcause_q;
      ADDR_MCYCLE:    old_val = mcycle_q[XLEN-1:0];
      ADDR_MINSTRET:  old_val = minstret_q[XLEN-1:0];
      ADDR_MCYCLEH: begin
        if (XLEN == 32) old_val = XLEN'(mcycle_q[63:32]);
        else            mapped  = 1'b0;
      end
      ADDR_MINSTRETH: begin
        if (XLEN == 32) old_val = XLEN'(minstret_q[63:32]);
        else            mapped  = 1'b0;
      end
      ADDR_MVENDORID: old_val = XLEN'(MVENDORID_VAL);
      ADDR_MARCHID:   old_val = XLEN'(MARCHID_VAL);
      default:        mapped  = 1'b0;
    endcase
  end

  // Effective write value and write qualification; a set/clear with a zero mask is a pure read.
  always_comb begin
    wr_val = bus.csr_wsrc_i;
    case (op)
      OP_RS:   wr_val = old_val | bus.csr_wsrc_i;
      OP_RC:   wr_val = old_val & ~bus.csr_wsrc_i;
      default: wr_val = bus.csr_wsrc_i;
    endcase
    write_req = bus.csr_valid_i && (op != OP_NONE) &&
                !(((op == OP_RS) || (op == OP_RC)) && (bus.csr_wsrc_i == '0));
    illegal   = bus.csr_valid_i &&
                (!mapped || ((addr[11:10] == 2'b11) && write_req));
    we        = write_req && !illegal && !bus.trap_i;
  end

  assign bus.csr_rdata_o   = old_val;
  assign bus.csr_illegal_o = illegal;
  assign bus.mtvec_o       = mtvec_q;
  assign bus.mepc_o        = mepc_q;
  assign bus.mie_o         = mstatus_mie;

  // mstatus: trap entry beats mret, which beats a software write.
  always_ff @(posedge clock) begin
    if (reset) begin
      mstatus_mie  <= 1'b0;
      mstatus_mpie <= 1'b0;
    end else if (bus.trap_i) begin
      mstatus_mpie <= mstatus_mie;
      mstatus_mie  <= 1'b0;
    end else if (bus.mret_i) begin
      mstatus_mie  <= mstatus_mpie;
      mstatus_mpie <= 1'b1;
    end else if (we && (addr == ADDR_MSTATUS)) begin
      mstatus_mie  <= wr_val[3];
      mstatus_mpie <= wr_val[7];
    end
  end

  // mepc/mcause: trap captures the faulting PC (word aligned) and cause; mret does not block writes here.
  always_ff @(posedge clock) begin
    if (reset) begin
      mepc_q   <= '0;
      mcause_q <= '0;
    end else if (bus.trap_i) begin
      mepc_q   <= {bus.trap_pc_i[XLEN-1:2], 2'b00};
      mcause_q <= bus.trap_cause_i;
    end else begin
      if (we && (addr == ADDR_MEPC))   mepc_q   <= {wr_val[XLEN-1:2], 2'b00};
      if (we && (addr == ADDR_MCAUSE)) mcause_q <= wr_val;
    end
  end

  // mtvec/mscratch: plain software-writable registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      mtvec_q    <= '0;
      mscratch_q <= '0;
    end else begin
      if (we && (addr == ADDR_MTVEC))    mtvec_q    <= wr_val;
      if (we && (addr == ADDR_MSCRATCH)) mscratch_q <= wr_val;
    end
  end

  // mcycle: free-running; a write to either half replaces that half and skips this cycle's increment.
  always_ff @(posedge clock) begin
    if (reset) begin
      mcycle_q <= '0;
    end else if (we && ((addr == ADDR_MCYCLE) || (addr == ADDR_MCYCLEH))) begin
      if (addr == ADDR_MCYCLE) begin
        if (XLEN == 32) mcycle_q[31:0] <= wr_val[31:0];
        else            mcycle_q       <= 64'(wr_val);
      end else begin
        mcycle_q[63:32] <= wr_val[31:0];
      end
    end else begin
      mcycle_q <= mcycle_q + 64'd1;
    end
  end

  // minstret: counts retire pulses; same write/suppress rules as mcycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      minstret_q <= '0;
    end else if (we && ((addr == ADDR_MINSTRET) || (addr == ADDR_MINSTRETH))) begin
      if (addr == ADDR_MINSTRET) begin
        if (XLEN == 32) minstret_q[31:0] <= wr_val[31:0];
        else            minstret_q       <= 64'(wr_val);
      end else begin
        minstret_q[63:32] <= wr_val[31:0];
      end
    end else if (bus.instret_i) begin
      minstret_q <= minstret_q + 64'd1;
    end
  end

endmodule

// File: tb/tb_csr_file_trap.sv
// Directed bench for csr_file_trap (XLEN=32) with hand-computed expectations.
module tb_csr_file_trap;

  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_RW   = 2'b01;
  localparam logic [1:0] OP_RS   = 2'b10;
  localparam logic [1:0] OP_RC   = 2'b11;

  logic clock;
  logic reset;
  int   compared;
  int   mismatched;

  logic [31:0] rd;
  logic        ill;

  csr_file_trap_if #(.XLEN(32)) bus ();

  csr_file_trap #(.XLEN(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic idleInputs();
    bus.csr_valid_i  = 1'b0;
    bus.csr_op_i     = OP_NONE;
    bus.csr_addr_i   = 12'h000;
    bus.csr_wsrc_i   = 32'h0;
    bus.trap_i       = 1'b0;
    bus.trap_cause_i = 32'h0;
    bus.trap_pc_i    = 32'h0;
    bus.mret_i       = 1'b0;
    bus.instret_i    = 1'b0;
  endtask

  // Drive one cycle of inputs, sample the combinational outputs, then clock once.
  task automatic applyStimulus(input logic valid, input logic [1:0] op, input logic [11:0] addr,
                               input logic [31:0] wsrc, input logic trap, input logic [31:0] cause,
                               input logic [31:0] pc, input logic mret, input logic instret,
                               output logic [31:0] old_v, output logic illegal_v);
    bus.csr_valid_i  = valid;
    bus.csr_op_i     = op;
    bus.csr_addr_i   = addr;
    bus.csr_wsrc_i   = wsrc;
    bus.trap_i       = trap;
    bus.trap_cause_i = cause;
    bus.trap_pc_i    = pc;
    bus.mret_i       = mret;
    bus.instret_i    = instret;
    #1;
    old_v     = bus.csr_rdata_o;
    illegal_v = bus.csr_illegal_o;
    @(posedge clock);
    #1;
    idleInputs();
  endtask

  // Combinational read with no clock edge.
  task automatic readCsr(input logic [11:0] addr, output logic [31:0] data, output logic illegal_v);
    bus.csr_valid_i = 1'b1;
    bus.csr_op_i    = OP_NONE;
    bus.csr_addr_i  = addr;
    #1;
    data      = bus.csr_rdata_o;
    illegal_v = bus.csr_illegal_o;
    bus.csr_valid_i = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    compared   = 0;
    mismatched = 0;
    idleInputs();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;

    // Reset state and read-only identification registers
    checkOutput("rst_mtvec_o", bus.mtvec_o, 32'h0);
    checkOutput("rst_mepc_o", bus.mepc_o, 32'h0);
    checkOutput("rst_mie_o", bus.mie_o, 1'b0);
    readCsr(12'hF11, rd, ill);
    checkOutput("mvendorid", rd, 32'h78797379);
    checkOutput("mvendorid_ill", ill, 1'b0);
    readCsr(12'hF12, rd, ill);
    checkOutput("marchid", rd, 32'h017dc6a3);
    readCsr(12'h305, rd, ill);
    checkOutput("rst_mtvec_rd", rd, 32'h0);
    readCsr(12'hB00, rd, ill);
    checkOutput("rst_mcycle", rd, 32'h0);

    // mtvec RW / RS / RC
    applyStimulus(1, OP_RW, 12'h305, 32'h80000100, 0, 0, 0, 0, 0, rd, ill);
    checkOutput("mtvec_rw_old", rd, 32'h0);
    checkOutput("mtvec_rw_o", bus.mtvec_o, 32'h80000100);
    applyStimulus(1, OP_RS, 12'h305, 32'h3, 0, 0, 0, 0, 0, rd, ill);
    checkOutput("mtvec_rs_old", rd, 32'h80000100);
    checkOutput("mtvec_rs_o", bus.mtvec_o, 32'h80000103);
    applyStimulus(1, OP_RC, 12'h305, 32'h100, 0, 0, 0, 0, 0, rd, ill);
    checkOutput("mtvec_rc_old", rd, 32'h80000103);
    checkOutput("mtvec_rc_o", bus.mtvec_o, 32'h80000003);
    readCsr(12'h305, rd, ill);
    checkOutput("mtvec_rc_rd", rd, 32'h80000003);

    // mstatus write, trap entry, mret
    applyStimulus(1, OP_RW, 12'h300, 32'h8, 0, 0, 0, 0, 0, rd, ill);
    checkOutput("mstatus_rw_mie_o", bus.mie_o, 1'b1);
    readCsr(12'h300, rd, ill);
    checkOutput("mstatus_rw_rd", rd, 32'h1808);
    applyStimulus(0, OP_NONE, 12'h000, 32'h0, 1, 32'hB, 32'h80000012, 0, 0, rd, ill);
    checkOutput("trap_mepc_o", bus.mepc_o, 32'h80000010);
    checkOutput("trap_mie_o", bus.mie_o, 1'b0);
    readCsr(12'h342, rd, ill);
    checkOutput("trap_mcause", rd, 32'hB);
    readCsr(12'h300, rd, ill);
    checkOutput("trap_mstatus", rd, 32'h1880);
    applyStimulus(0, OP_NONE, 12'h000, 32'h0, 0, 0, 0, 1, 0, rd, ill);
    readCsr(12'h300, rd, ill);
    checkOutput("mret_mstatus", rd, 32'h1888);
    checkOutput("mret_mie_o", bus.mie_o, 1'b1);

    // Trap beats a same-cycle write to mepc
    applyStimulus(1, OP_RW, 12'h341, 32'h1234, 1, 32'h2, 32'h80000020, 0, 0, rd, ill);
    checkOutput("trapwr_mepc_o", bus.mepc_o, 32'h80000020);
    readCsr(12'h342, rd, ill);
    checkOutput("trapwr_mcause", rd, 32'h2);
    readCsr(12'h300, rd, ill);
    checkOutput("trapwr_mstatus", rd, 32'h1880);

    // Illegal accesses
    applyStimulus(1, OP_RW, 12'hF11, 32'h1, 0, 0, 0, 0, 0, rd, ill);
    checkOutput("ro_write_ill", ill, 1'b1);
    readCsr(12'hF11, rd, ill);
    checkOutput("ro_write_keep", rd, 32'h78797379);
    applyStimulus(1, OP_RS, 12'hF11, 32'h0, 0, 0, 0, 0, 0, rd, ill);
    checkOutput("ro_rs0_ill", ill, 1'b0);
    applyStimulus(1, OP_NONE, 12'h7C0, 32'h0, 0, 0, 0, 0, 0, rd, ill);
    checkOutput("unmapped_ill", ill, 1'b1);
    checkOutput("unmapped_rd", rd, 32'h0);

    // mepc alignment, mret blocking an mstatus write, mscratch
    applyStimulus(1, OP_RW, 12'h341, 32'h1237, 0, 0, 0, 0, 0, rd, ill);
    checkOutput("mepc_align", bus.mepc_o, 32'h1234);
    applyStimulus(1, OP_RW, 12'h300, 32'h0, 0, 0, 0, 1, 0, rd, ill);
    checkOutput("mret_wr_mie_o", bus.mie_o, 1'b1);
    readCsr(12'h300, rd, ill);
    checkOutput("mret_wr_mstatus", rd, 32'h1888);
    applyStimulus(1, OP_RW, 12'h340, 32'hDEADBEEF, 0, 0, 0, 0, 0, rd, ill);
    readCsr(12'h340, rd, ill);
    checkOutput("mscratch_rw", rd, 32'hDEADBEEF);
    applyStimulus(1, OP_RW, 12'h340, 32'hCAFEF00D, 1, 32'h4, 32'h1234, 0, 0, rd, ill);
    readCsr(12'h340, rd, ill);
    checkOutput("mscratch_trap_keep", rd, 32'hDEADBEEF);

    // mcycle low-to-high carry
    applyStimulus(1, OP_RW, 12'hB00, 32'hFFFFFFFF, 0, 0, 0, 0, 0, rd, ill);
    applyStimulus(1, OP_RW, 12'hB80, 32'h0, 0, 0, 0, 0, 0, rd, ill);
    readCsr(12'hB00, rd, ill);
    checkOutput("mcycle_lo_held", rd, 32'hFFFFFFFF);
    readCsr(12'hB80, rd, ill);
    checkOutput("mcycle_hi_wr", rd, 32'h0);
    repeat (2) @(posedge clock);
    #1;
    readCsr(12'hB00, rd, ill);
    checkOutput("mcycle_lo_carry", rd, 32'h1);
    readCsr(12'hB80, rd, ill);
    checkOutput("mcycle_hi_carry", rd, 32'h1);
    applyStimulus(1, OP_RW, 12'hB00, 32'h50, 0, 0, 0, 0, 0, rd, ill);
    readCsr(12'hB00, rd, ill);
    checkOutput("mcycle_wr_noinc", rd, 32'h50);
    @(posedge clock);
    #1;
    readCsr(12'hB00, rd, ill);
    checkOutput("mcycle_next", rd, 32'h51);

    // minstret counts only retire pulses; a write beats a same-cycle pulse
    applyStimulus(1, OP_RW, 12'hB02, 32'h0, 0, 0, 0, 0, 0, rd, ill);
    applyStimulus(1, OP_RW, 12'hB82, 32'h0, 0, 0, 0, 0, 0, rd, ill);
    applyStimulus(0, OP_NONE, 12'h000, 32'h0, 0, 0, 0, 0, 1, rd, ill);
    applyStimulus(0, OP_NONE, 12'h000, 32'h0, 0, 0, 0, 0, 0, rd, ill);
    applyStimulus(0, OP_NONE, 12'h000, 32'h0, 0, 0, 0, 0, 1, rd, ill);
    applyStimulus(0, OP_NONE, 12'h000, 32'h0, 0, 0, 0, 0, 0, rd, ill);
    readCsr(12'hB02, rd, ill);
    checkOutput("minstret_pulses", rd, 32'h2);
    readCsr(12'hB82, rd, ill);
    checkOutput("minstreth", rd, 32'h0);
    applyStimulus(1, OP_RW, 12'hB02, 32'h10, 0, 0, 0, 0, 1, rd, ill);
    readCsr(12'hB02, rd, ill);
    checkOutput("minstret_wr_noinc", rd, 32'h10);

    // Reset together with trap, write and retire pulse
    bus.csr_valid_i  = 1'b1;
    bus.csr_op_i     = OP_RW;
    bus.csr_addr_i   = 12'h305;
    bus.csr_wsrc_i   = 32'hFF;
    bus.trap_i       = 1'b1;
    bus.trap_cause_i = 32'h5;
    bus.trap_pc_i    = 32'h104;
    bus.instret_i    = 1'b1;
    reset            = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    idleInputs();
    checkOutput("rst2_mtvec_o", bus.mtvec_o, 32'h0);
    checkOutput("rst2_mepc_o", bus.mepc_o, 32'h0);
    checkOutput("rst2_mie_o", bus.mie_o, 1'b0);
    readCsr(12'h342, rd, ill);
    checkOutput("rst2_mcause", rd, 32'h0);
    readCsr(12'h300, rd, ill);
    checkOutput("rst2_mstatus", rd, 32'h1800);
    readCsr(12'hB00, rd, ill);
    checkOutput("rst2_mcycle", rd, 32'h0);
    readCsr(12'hB02, rd, ill);
    checkOutput("rst2_minstret", rd, 32'h0);
    readCsr(12'h340, rd, ill);
    checkOutput("rst2_mscratch", rd, 32'h0);
    @(posedge clock);
    #1;
    readCsr(12'hB00, rd, ill);
    checkOutput("rst2_mcycle_restart", rd, 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
